// File: rtl/bus_mem_target_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_target_if
// Description : CPU memory-bus handshake bundle between the CPU (master)
//               and a bus target (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_mem_target_if;
  logic [15:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_data_out;
  logic        bus_done;

  modport master (
    output bus_address_in,
    output bus_data_in,
    output bus_read,
    output bus_write,
    input  bus_data_out,
    input  bus_done
  );

  modport slave (
    input  bus_address_in,
    input  bus_data_in,
    input  bus_read,
    input  bus_write,
    output bus_data_out,
    output bus_done
  );
endinterface
`default_nettype wire

// File: rtl/bus_mem_target.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_target
// Description : Memory-bus target serving a byte-wide on-chip RAM plus a
//               3-byte MMIO window (GPIO out, GPIO in, status). Handshake
//               FSM with programmable wait states and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_target #(
  parameter int          RAM_AW      = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bus_mem_target_if.slave        bus,
  input  wire logic [7:0]        gpio_in,
  output logic      [7:0]        gpio_out,
  output logic                   bus_error
);

  localparam logic [15:0] ADDR_GPIO_OUT = MMIO_BASE;
  localparam logic [15:0] ADDR_GPIO_IN  = MMIO_BASE + 16'd1;
  localparam logic [15:0] ADDR_STATUS   = MMIO_BASE + 16'd2;
  localparam logic [3:0]  WAIT_LOAD     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        both_q, both_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  gpio_q, gpio_d;
  logic        err_q, err_d;
  logic [7:0]  sync1_q, sync2_q;

  logic        req_w;
  logic        is_ram_w;
  logic        ram_we_w;
  logic        err_set_w;
  logic        err_clr_w;
  logic [7:0]  rd_byte_w;
  logic [RAM_AW-1:0] ram_idx_w;

  logic [7:0]  mem [0:(2**RAM_AW)-1];

  assign req_w     = bus.bus_read | bus.bus_write;
  assign is_ram_w  = (addr_q >> RAM_AW) == 16'h0000;
  assign ram_idx_w = addr_q[RAM_AW-1:0];

  assign bus.bus_done     = done_q;
  assign bus.bus_data_out = rdata_q;
  assign gpio_out         = gpio_q;
  assign bus_error        = err_q;

  // Read-data mux over the latched address; unmapped space reads as 0xFF.
  always_comb begin
    rd_byte_w = 8'hFF;
    if (is_ram_w) begin
      rd_byte_w = mem[ram_idx_w];
    end else if (addr_q == ADDR_GPIO_OUT) begin
      rd_byte_w = gpio_q;
    end else if (addr_q == ADDR_GPIO_IN) begin
      rd_byte_w = sync2_q;
    end else if (addr_q == ADDR_STATUS) begin
      rd_byte_w = {7'b0, err_q};
    end
  end

  // Handshake FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    both_d    = both_q;
    done_d    = done_q;
    rdata_d   = rdata_q;
    gpio_d    = gpio_q;
    err_set_w = 1'b0;
    err_clr_w = 1'b0;
    ram_we_w  = 1'b0;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (req_w) begin
          addr_d  = bus.bus_address_in;
          wdata_d = bus.bus_data_in;
          wr_d    = bus.bus_write;
          both_d  = bus.bus_read & bus.bus_write;
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A request withdrawn before the access is a protocol abort.
        if (!req_w) begin
          err_set_w = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        done_d  = 1'b1;
        state_d = S_DONE;
        if (both_q) begin
          // Simultaneous read+write: flag it, suppress the write.
          err_set_w = 1'b1;
          rdata_d   = 8'hFF;
        end else if (wr_q) begin
          if (is_ram_w) begin
            ram_we_w = 1'b1;
          end else if (addr_q == ADDR_GPIO_OUT) begin
            gpio_d = wdata_q;
          end else if (addr_q == ADDR_STATUS) begin
            err_clr_w = wdata_q[0];
          end
        end else begin
          rdata_d = rd_byte_w;
        end
      end
      S_DONE: begin
        if (!req_w) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A set in the same cycle as a clear takes priority.
    err_d = err_set_w | (err_q & ~err_clr_w);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
      gpio_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      gpio_q  <= gpio_d;
      err_q   <= err_d;
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we_w) begin
      mem[ram_idx_w] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_target
// Description : Directed self-checking bench for bus_mem_target. Instance A
//               uses one wait state, instance B uses four.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mem_target;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_in_a;
  logic [7:0] gpio_in_b;
  logic [7:0] gpio_out_a, gpio_out_b;
  logic       err_a, err_b;

  int checks = 0;
  int errors = 0;

  bus_mem_target_if ifa ();
  bus_mem_target_if ifb ();

  bus_mem_target #(.RAM_AW(10), .WAIT_STATES(1), .MMIO_BASE(16'hFF00)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifa.slave),
    .gpio_in   (gpio_in_a),
    .gpio_out  (gpio_out_a),
    .bus_error (err_a)
  );

  bus_mem_target #(.RAM_AW(10), .WAIT_STATES(4), .MMIO_BASE(16'hFF00)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifb.slave),
    .gpio_in   (gpio_in_b),
    .gpio_out  (gpio_out_b),
    .bus_error (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_start(input bit sel, input logic [15:0] addr, input logic [7:0] data,
                           input logic rd, input logic wr);
    if (sel) begin
      ifb.bus_address_in = addr; ifb.bus_data_in = data; ifb.bus_read = rd; ifb.bus_write = wr;
    end else begin
      ifa.bus_address_in = addr; ifa.bus_data_in = data; ifa.bus_read = rd; ifa.bus_write = wr;
    end
  endtask

  task automatic req_drop(input bit sel);
    if (sel) begin
      ifb.bus_read = 1'b0; ifb.bus_write = 1'b0;
    end else begin
      ifa.bus_read = 1'b0; ifa.bus_write = 1'b0;
    end
  endtask

  // Full transaction: start, wait for done (latency checked), release,
  // confirm done falls one cycle after release. Returns the read data.
  task automatic xfer(input string tag, input bit sel, input logic [15:0] addr,
                      input logic [7:0] data, input logic rd, input logic wr,
                      input int exp_lat, output logic [7:0] rdata);
    int lat;
    logic d;
    lat = -1;
    req_start(sel, addr, data, rd, wr);
    for (int k = 1; k <= 40; k++) begin
      step();
      d = sel ? ifb.bus_done : ifa.bus_done;
      if (d) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: observed no bus_done expected done within 40 cycles", tag);
    end else begin
      chk({tag, "_lat"}, 8'(lat), 8'(exp_lat));
    end
    rdata = sel ? ifb.bus_data_out : ifa.bus_data_out;
    req_drop(sel);
    step();
    chk({tag, "_done_fall"}, 8'(sel ? ifb.bus_done : ifa.bus_done), 8'h00);
  endtask

  logic [7:0] rd;

  initial begin
    rst = 1'b1;
    gpio_in_a = 8'h00;
    gpio_in_b = 8'h00;
    req_start(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    req_start(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    step();
    step();

    // 1: reset state, then RAM write/read with one wait state.
    chk("rst_done",  8'(ifa.bus_done), 8'h00);
    chk("rst_dout",  ifa.bus_data_out, 8'h00);
    chk("rst_gpio",  gpio_out_a, 8'h00);
    chk("rst_err",   8'(err_a), 8'h00);
    rst = 1'b0;
    step();
    xfer("t1_wr", 1'b0, 16'h0010, 8'h5A, 1'b0, 1'b1, 3, rd);
    xfer("t1_rd", 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t1_rdata", rd, 8'h5A);

    // 2: GPIO out write/readback, GPIO in through the synchroniser.
    xfer("t2_gwr", 1'b0, 16'hFF00, 8'h3C, 1'b0, 1'b1, 3, rd);
    chk("t2_gpio_out", gpio_out_a, 8'h3C);
    xfer("t2_grd", 1'b0, 16'hFF00, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t2_gpio_rd", rd, 8'h3C);
    gpio_in_a = 8'hA5;
    step(); step(); step();
    xfer("t2_gin", 1'b0, 16'hFF01, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t2_gpio_in", rd, 8'hA5);

    // 3: done is held while the request is held.
    req_start(1'b0, 16'h0010, 8'h00, 1'b1, 1'b0);
    step(); step(); step(); step();
    chk("t3_done_up", 8'(ifa.bus_done), 8'h01);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_done_hold", 8'(ifa.bus_done), 8'h01);
    end
    chk("t3_rdata", ifa.bus_data_out, 8'h5A);
    req_drop(1'b0);
    step();
    chk("t3_done_fall", 8'(ifa.bus_done), 8'h00);
    xfer("t3_next", 1'b0, 16'hFF00, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t3_next_rdata", rd, 8'h3C);

    // 4: simultaneous read+write is an error and does not write.
    xfer("t4_seed", 1'b0, 16'h0020, 8'h11, 1'b0, 1'b1, 3, rd);
    xfer("t4_both", 1'b0, 16'h0020, 8'h77, 1'b1, 1'b1, 3, rd);
    chk("t4_both_dout", rd, 8'hFF);
    chk("t4_err_set", 8'(err_a), 8'h01);
    xfer("t4_ram", 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t4_ram_kept", rd, 8'h11);
    xfer("t4_stat", 1'b0, 16'hFF02, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t4_status_rd", rd, 8'h01);
    xfer("t4_nclr", 1'b0, 16'hFF02, 8'hFE, 1'b0, 1'b1, 3, rd);
    chk("t4_err_noclr", 8'(err_a), 8'h01);
    xfer("t4_clr", 1'b0, 16'hFF02, 8'h01, 1'b0, 1'b1, 3, rd);
    chk("t4_err_clr", 8'(err_a), 8'h00);

    // 5: unmapped read; abort during WAIT on the four-wait-state target.
    xfer("t5_unmap", 1'b0, 16'h8000, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t5_unmap_rd", rd, 8'hFF);
    chk("t5_unmap_err", 8'(err_a), 8'h00);
    xfer("t5_unwr", 1'b0, 16'h8001, 8'h42, 1'b0, 1'b1, 3, rd);
    chk("t5_unwr_dout", rd, 8'hFF);
    chk("t5_unwr_err", 8'(err_a), 8'h00);
    req_start(1'b1, 16'h0005, 8'h00, 1'b1, 1'b0);
    step(); step();
    req_drop(1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_abort_nodone", 8'(ifb.bus_done), 8'h00);
    end
    chk("t5_abort_err", 8'(err_b), 8'h01);
    xfer("t5_b_wr", 1'b1, 16'h0005, 8'h66, 1'b0, 1'b1, 6, rd);
    xfer("t5_b_rd", 1'b1, 16'h0005, 8'h00, 1'b1, 1'b0, 6, rd);
    chk("t5_b_rdata", rd, 8'h66);

    // 6: asynchronous reset in the middle of a transaction.
    req_start(1'b0, 16'h0010, 8'h00, 1'b1, 1'b0);
    step();
    req_drop(1'b0);
    step();
    chk("t6_pre_err", 8'(err_a), 8'h01);
    req_start(1'b0, 16'h0010, 8'h00, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_done", 8'(ifa.bus_done), 8'h00);
    chk("t6_rst_gpio", gpio_out_a, 8'h00);
    chk("t6_rst_err",  8'(err_a), 8'h00);
    chk("t6_rst_dout", ifa.bus_data_out, 8'h00);
    req_drop(1'b0);
    step();
    rst = 1'b0;
    step();
    xfer("t6_after", 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 3, rd);
    chk("t6_after_rd", rd, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
